mul_8_seq: RTL and testbench

Sequential 8x8 unsigned multiplier that time-shares a single `mul_4` 4x4 multiplier across four cycles instead of instantiating four. A small FSM captures operands through a valid/ready handshake and steps the shared multiplier through the four nibble partial products (LL, HL, LH, HH). It accumulates the shifted results into a 16-bit register and presents the product through an output valid/ready handshake. It is the area-reduced alternative to the fully combinational 8-bit multiplier and drops into the same datapath slots wherever a multi-cycle latency is acceptable.

---
 rtl/mul_8_seq.sv | 129 ++++++++++++
 tb/tb_mul_8_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_8_seq.sv
// Sequential 8x8 unsigned multiplier: one shared 4x4 multiplier is stepped through the
// four nibble partial products, with valid/ready handshakes on both operands and result.

module mul_4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);
    assign p_o = {4'h0, a_i} * {4'h0, b_i};
endmodule

module mul_8_seq (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [7:0]    a_i,
    input  logic [7:0]    b_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [15:0]   prod_o,
    output logic          busy_o
);
    localparam int unsigned N = 8;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [1:0]       r_step;
    logic [2*N-1:0]   r_acc;
    logic [2*N-1:0]   r_prod;

    logic             w_accept;
    logic [3:0]       w_mul_a;
    logic [3:0]       w_mul_b;
    logic [7:0]       w_pp;
    logic [2*N-1:0]   w_addend;
    logic [2*N-1:0]   w_sum;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (in_valid_i) w_state_next = StCalc;
            end
            StCalc: begin
                if (r_step == 2'd3) w_state_next = StDone;
            end
            StDone: begin
                if (out_ready_i) w_state_next = in_valid_i ? StCalc : StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // In DONE the slot frees up in the same cycle the consumer takes the result.
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        unique case (r_state)
            StIdle:  in_ready_o = 1'b1;
            StCalc:  busy_o = 1'b1;
            StDone: begin
                in_ready_o  = out_ready_i;
                out_valid_o = 1'b1;
            end
            default: in_ready_o = 1'b0;
        endcase
    end

    assign w_accept = in_valid_i & in_ready_o;

    // Step bit 0 selects the high multiplicand nibble, bit 1 the high multiplier nibble.
    assign w_mul_a = r_step[0] ? r_a[7:4] : r_a[3:0];
    assign w_mul_b = r_step[1] ? r_b[7:4] : r_b[3:0];

    mul_4 u_mul_4 (
        .a_i (w_mul_a),
        .b_i (w_mul_b),
        .p_o (w_pp)
    );

    always_comb begin
        w_addend = '0;
        unique case (r_step)
            2'd0:    w_addend = {8'h00, w_pp};
            2'd1:    w_addend = {4'h0, w_pp, 4'h0};
            2'd2:    w_addend = {4'h0, w_pp, 4'h0};
            2'd3:    w_addend = {w_pp, 8'h00};
            default: w_addend = '0;
        endcase
    end

    assign w_sum = r_acc + w_addend;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a    <= '0;
            r_b    <= '0;
            r_step <= '0;
            r_acc  <= '0;
            r_prod <= '0;
        end else if (w_accept) begin
            r_a    <= a_i;
            r_b    <= b_i;
            r_step <= '0;
            r_acc  <= '0;
        end else if (r_state == StCalc) begin
            r_acc  <= w_sum;
            r_step <= r_step + 2'd1;
            if (r_step == 2'd3) r_prod <= w_sum;
        end
    end

    assign prod_o = r_prod;

endmodule

// File: tb/tb_mul_8_seq.sv
// Scoreboard bench for mul_8_seq: directed vectors push expected products, a monitor pops
// and compares on every consumed result; latency, backpressure and reset checked inline.

module tb_mul_8_seq;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [7:0]  a_i = '0;
    logic [7:0]  b_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [15:0] prod_o;
    logic        busy_o;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [15:0] sb[$];

    mul_8_seq dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .prod_o      (prod_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic void chk(string nm, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    // Monitor: every consumed result must match the oldest expected product.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni && out_valid_o && out_ready_i) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_result: got %h, expected none", prod_o);
                end else begin
                    chk("sb_prod", prod_o, sb.pop_front());
                end
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        bit ok = 0;
        in_valid_i = 1'b1;
        a_i = a;
        b_i = b;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (in_ready_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready 0, expected 1");
        end
        @(posedge clk_i);
        #1;
        if (ok) sb.push_back(exp);
        in_valid_i = 1'b0;
        a_i = 8'($urandom);
        b_i = 8'($urandom);
    endtask

    // Cycles 1-4 busy with operands scrambled; cycle 5 result valid.
    task automatic check_calc(input logic [15:0] exp);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("busy", {15'h0, busy_o}, 16'h1);
            chk("calc_in_ready", {15'h0, in_ready_o}, 16'h0);
            chk("calc_out_valid", {15'h0, out_valid_o}, 16'h0);
            a_i = 8'($urandom);
            b_i = 8'($urandom);
        end
        @(negedge clk_i);
        chk("latency_out_valid", {15'h0, out_valid_o}, 16'h1);
        chk("latency_busy", {15'h0, busy_o}, 16'h0);
        chk("latency_prod", prod_o, exp);
    endtask

    initial begin
        #12;
        chk("rst_in_ready", {15'h0, in_ready_o}, 16'h1);
        chk("rst_out_valid", {15'h0, out_valid_o}, 16'h0);
        chk("rst_busy", {15'h0, busy_o}, 16'h0);
        chk("rst_prod", prod_o, 16'h0000);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Single op, then back to IDLE holding the result.
        send(8'h12, 8'h34, 16'h03A8);
        check_calc(16'h03A8);
        @(negedge clk_i);
        chk("idle_out_valid", {15'h0, out_valid_o}, 16'h0);
        chk("idle_in_ready", {15'h0, in_ready_o}, 16'h1);
        chk("idle_prod_hold", prod_o, 16'h03A8);
        @(posedge clk_i);
        #1;

        // Corners
        send(8'hFF, 8'hFF, 16'hFE01);
        check_calc(16'hFE01);
        @(posedge clk_i); #1;
        send(8'h00, 8'hA5, 16'h0000);
        check_calc(16'h0000);
        @(posedge clk_i); #1;
        send(8'hF0, 8'h0F, 16'h0E10);
        check_calc(16'h0E10);
        @(posedge clk_i); #1;
        send(8'h01, 8'h80, 16'h0080);
        check_calc(16'h0080);
        @(posedge clk_i); #1;

        // Backpressure: result held for 3 cycles, then consumed.
        out_ready_i = 1'b0;
        send(8'h0F, 8'h10, 16'h00F0);
        check_calc(16'h00F0);
        in_valid_i = 1'b1;
        chk("bp_in_ready0", {15'h0, in_ready_o}, 16'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            chk("bp_out_valid", {15'h0, out_valid_o}, 16'h1);
            chk("bp_prod", prod_o, 16'h00F0);
            chk("bp_in_ready", {15'h0, in_ready_o}, 16'h0);
        end
        in_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b1;
        #1;
        chk("bp_release_in_ready", {15'h0, in_ready_o}, 16'h1);
        @(posedge clk_i);
        #1;
        chk("bp_retired", {15'h0, out_valid_o}, 16'h0);

        // Back-to-back: new operands accepted on the edge the previous result retires.
        send(8'h11, 8'h11, 16'h0121);
        check_calc(16'h0121);
        in_valid_i = 1'b1;
        a_i = 8'h03;
        b_i = 8'h05;
        #1;
        chk("b2b_in_ready", {15'h0, in_ready_o}, 16'h1);
        @(posedge clk_i);
        #1;
        sb.push_back(16'h000F);
        in_valid_i = 1'b0;
        check_calc(16'h000F);
        @(posedge clk_i); #1;

        // Reset during step 2 aborts the operation.
        send(8'h55, 8'hAA, 16'h3872);
        @(negedge clk_i);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("midrst_out_valid", {15'h0, out_valid_o}, 16'h0);
        chk("midrst_busy", {15'h0, busy_o}, 16'h0);
        chk("midrst_in_ready", {15'h0, in_ready_o}, 16'h1);
        chk("midrst_prod", prod_o, 16'h0000);
        sb.delete();
        #2;
        rst_ni = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            chk("aborted_no_valid", {15'h0, out_valid_o}, 16'h0);
        end
        @(posedge clk_i); #1;
        send(8'h07, 8'h09, 16'h003F);
        check_calc(16'h003F);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;

        chk("sb_drained", 16'(sb.size()), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
